// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard detection and operand forwarding between decode and the post-decode
// stages. A shift-register tracker records in-flight register writers for
// DEPTH stages (index 0 = EX, 1 = MEM, 2 = WB for the default DEPTH=3).
// Sources are resolved against the youngest matching producer. A load whose
// result is not yet forwardable causes a stall. A taken branch flushes the
// issuing slot.
//
// Issue handshake: issue_valid has no ready input. stall acts as the
// back-pressure. While stall=1 the issuing instruction is not accepted and
// decode must present it again on the next cycle. flush=1 discards the
// issuing instruction outright. An instruction is accepted exactly on a cycle
// where issue_valid=1, stall=0 and flush=0.
//
// Build option: define ZERO_REG_EN to hardwire register 0 to zero. When it is
// undefined, r0 is an ordinary register.
//
// Ports:
//   CLOCK_50            in   clock, rising edge
//   reset               in   asynchronous, active-high
//   issue_valid         in   decode presents an instruction
//   issue_dr            in   destination register
//   issue_wb_en         in   instruction writes the register file
//   issue_is_load       in   instruction is a load
//   src1/src2           in   source register addresses
//   src1_used/src2_used in   source operand is actually read
//   branch_taken        in   EX resolved a taken branch this cycle
//   stage_result        in   per-stage result bus; slice k belongs to stage k
//   rf_rdata1/2         in   register file read data
//   operand1/2          out  resolved operands to EX
//   fwd_sel1/2          out  0 = register file, k+1 = stage k
//   stall               out  hold FE/ID latches and PC
//   flush               out  squash the issuing slot
//   inflight_cnt        out  valid writer entries in the tracker
//   stall_cycles        out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
    parameter  int DATA_W   = 16,
    parameter  int REG_AW   = 3,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_RDY = 1,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = REG_AW + 2,
    localparam int INF_W    = $clog2(DEPTH + 1)
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_dr,
    input  logic                    issue_wb_en,
    input  logic                    issue_is_load,
    input  logic [REG_AW-1:0]       src1,
    input  logic [REG_AW-1:0]       src2,
    input  logic                    src1_used,
    input  logic                    src2_used,
    input  logic                    branch_taken,
    input  logic [DEPTH*DATA_W-1:0] stage_result,
    input  logic [DATA_W-1:0]       rf_rdata1,
    input  logic [DATA_W-1:0]       rf_rdata2,
    output logic [DATA_W-1:0]       operand1,
    output logic [DATA_W-1:0]       operand2,
    output logic [SEL_W-1:0]        fwd_sel1,
    output logic [SEL_W-1:0]        fwd_sel2,
    output logic                    stall,
    output logic                    flush,
    output logic [INF_W-1:0]        inflight_cnt,
    output logic [CNT_W-1:0]        stall_cycles
);

    typedef struct packed {
        logic [DATA_W-1:0] opnd;
        logic [SEL_W-1:0]  sel;
        logic              haz;
    } res_t;

    // Tracker state: one entry per post-decode stage.
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0]             ld_q,  ld_d;
    logic [DEPTH-1:0][REG_AW-1:0] dr_q,  dr_d;
    logic [INF_W-1:0]             inflight_cnt_q, inflight_cnt_d;
    logic [CNT_W-1:0]             stall_cycles_q, stall_cycles_d;

    res_t res1, res2;
    logic accept_wr;
    logic dr_is_zero;

    // Resolve one source operand against the tracker. The scan runs from the
    // oldest entry to the youngest so the last hit kept is the youngest
    // producer.
    function automatic res_t resolve(input logic [REG_AW-1:0] src,
                                     input logic              used,
                                     input logic [DATA_W-1:0] rf);
        res_t r;
        logic hit;
        logic win_ld;
        logic zero_src;
        int   win;
        hit    = 1'b0;
        win_ld = 1'b0;
        win    = 0;
`ifdef ZERO_REG_EN
        zero_src = (src == '0);
`else
        zero_src = 1'b0;
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld_q[k] && used && (dr_q[k] == src) && !zero_src) begin
                hit    = 1'b1;
                win    = k;
                win_ld = ld_q[k];
            end
        end
        r.haz = hit && win_ld && (win < LOAD_RDY);
        if (zero_src) begin
            r.opnd = '0;
            r.sel  = '0;
        end else if (hit) begin
            // A hazarded match still reports its stage; EX sees a bubble anyway.
            r.opnd = stage_result[win*DATA_W +: DATA_W];
            r.sel  = SEL_W'(win + 1);
        end else begin
            r.opnd = rf;
            r.sel  = '0;
        end
        return r;
    endfunction

    always_comb begin
        res1 = resolve(src1, src1_used, rf_rdata1);
        res2 = resolve(src2, src2_used, rf_rdata2);
    end

    // A taken branch wins over a load-use stall: the slot is squashed instead.
    assign flush    = branch_taken;
    assign stall    = issue_valid && (res1.haz || res2.haz) && !branch_taken;
    assign operand1 = res1.opnd;
    assign operand2 = res2.opnd;
    assign fwd_sel1 = res1.sel;
    assign fwd_sel2 = res2.sel;

    always_comb begin
`ifdef ZERO_REG_EN
        dr_is_zero = (issue_dr == '0);
`else
        dr_is_zero = 1'b0;
`endif
        accept_wr = issue_valid && issue_wb_en && !stall && !flush && !dr_is_zero;
    end

    // Tracker shift, entry count and stall counter.
    always_comb begin
        vld_d = '0;
        ld_d  = '0;
        dr_d  = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            vld_d[k] = vld_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dr_d[k]  = dr_q[k-1];
        end
        vld_d[0] = accept_wr;
        ld_d[0]  = accept_wr && issue_is_load;
        dr_d[0]  = issue_dr;

        inflight_cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight_cnt_d = inflight_cnt_d + INF_W'(vld_d[k]);
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vld_q          <= '0;
            ld_q           <= '0;
            dr_q           <= '0;
            inflight_cnt_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            vld_q          <= vld_d;
            ld_q           <= ld_d;
            dr_q           <= dr_d;
            inflight_cnt_q <= inflight_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign inflight_cnt = inflight_cnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule
